// File: rtl/heichips25_multi_wrapper_if.sv
// Project-select handshake between a controller and the multi-project pad wrapper.
// The controller drives the request; the wrapper reports acceptance, errors and progress.
interface heichips25_multi_wrapper_if #(
    parameter int NUM_PROJECTS = 4
);
    localparam int ID_W = $clog2(NUM_PROJECTS);

    logic            sel_valid;
    logic            sel_ready;
    logic [ID_W-1:0] sel_id;
    logic            sel_err;
    logic            busy;
    logic [ID_W-1:0] cur_id;

    modport master (
        output sel_valid,
        output sel_id,
        input  sel_ready,
        input  sel_err,
        input  busy,
        input  cur_id
    );

    modport slave (
        input  sel_valid,
        input  sel_id,
        output sel_ready,
        output sel_err,
        output busy,
        output cur_id
    );
endinterface

// File: rtl/heichips25_multi_wrapper.sv
// Runtime-selectable pad wrapper: one of NUM_PROJECTS slots owns the tile pins.
// Switching darkens the pads, holds the incoming slot in reset, then connects it.
module heichips25_multi_wrapper #(
    parameter int NUM_PROJECTS = 4,
    parameter int IO_W         = 8,
    parameter int DEFAULT_ID   = 0,
    parameter int GUARD_CYCLES = 4,
    parameter int RST_CYCLES   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    heichips25_multi_wrapper_if.slave    sel,
    input  logic [NUM_PROJECTS*IO_W-1:0] proj_uo_out,
    input  logic [NUM_PROJECTS*IO_W-1:0] proj_uio_out,
    input  logic [NUM_PROJECTS*IO_W-1:0] proj_uio_oe,
    output logic [NUM_PROJECTS-1:0]      proj_ena,
    output logic [NUM_PROJECTS-1:0]      proj_rst_n,
    output logic [IO_W-1:0]              uo_out,
    output logic [IO_W-1:0]              uio_out,
    output logic [IO_W-1:0]              uio_oe
);
    localparam int ID_W    = $clog2(NUM_PROJECTS);
    localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_RESET  = 2'd2;

    logic [1:0]              state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [ID_W-1:0]         cur_id, cur_id_d;
    logic [ID_W-1:0]         nxt_id, nxt_id_d;
    logic                    err_q, err_d;
    logic                    id_ok;
    logic [NUM_PROJECTS-1:0] ena_d, rst_n_d;
    logic [IO_W-1:0]         slot_uo, slot_uio, slot_oe;
    logic [IO_W-1:0]         uo_q, uio_q, oe_q;
    logic                    pad_on;

    assign id_ok = int'(sel.sel_id) < NUM_PROJECTS;

    // Re-selecting the current slot is a legal request and forces a full re-reset.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cur_id_d = cur_id;
        nxt_id_d = nxt_id;
        err_d    = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (sel.sel_valid) begin
                    if (id_ok) begin
                        nxt_id_d = sel.sel_id;
                        cnt_d    = CNT_W'(GUARD_CYCLES - 1);
                        state_d  = ST_DRAIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    cur_id_d = nxt_id;
                    cnt_d    = CNT_W'(RST_CYCLES - 1);
                    state_d  = ST_RESET;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_RESET: begin
                if (cnt == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = CNT_W'(RST_CYCLES - 1);
            end
        endcase
    end

    // Slot controls come from next-state values so the registered outputs never glitch.
    always_comb begin
        ena_d   = '0;
        rst_n_d = '0;
        for (int k = 0; k < NUM_PROJECTS; k++) begin
            ena_d[k]   = ena && (ID_W'(k) == cur_id_d) && (state_d != ST_DRAIN);
            rst_n_d[k] = (ID_W'(k) == cur_id_d) && (state_d != ST_RESET);
        end
    end

    always_comb begin
        slot_uo  = '0;
        slot_uio = '0;
        slot_oe  = '0;
        for (int k = 0; k < NUM_PROJECTS; k++) begin
            if (ID_W'(k) == cur_id) begin
                slot_uo  = proj_uo_out[k*IO_W +: IO_W];
                slot_uio = proj_uio_out[k*IO_W +: IO_W];
                slot_oe  = proj_uio_oe[k*IO_W +: IO_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RESET;
            cnt        <= CNT_W'(RST_CYCLES - 1);
            cur_id     <= ID_W'(DEFAULT_ID);
            nxt_id     <= ID_W'(DEFAULT_ID);
            err_q      <= 1'b0;
            proj_ena   <= '0;
            proj_rst_n <= '0;
            uo_q       <= '0;
            uio_q      <= '0;
            oe_q       <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cur_id     <= cur_id_d;
            nxt_id     <= nxt_id_d;
            err_q      <= err_d;
            proj_ena   <= ena_d;
            proj_rst_n <= rst_n_d;
            uo_q       <= slot_uo;
            uio_q      <= slot_uio;
            oe_q       <= slot_oe;
        end
    end

    // Pads are gated by the current state so they go dark on the edge that accepts a switch.
    assign pad_on  = (state == ST_ACTIVE) && ena;
    assign uo_out  = pad_on ? uo_q  : '0;
    assign uio_out = pad_on ? uio_q : '0;
    assign uio_oe  = pad_on ? oe_q  : '0;

    assign sel.sel_ready = (state == ST_ACTIVE);
    assign sel.busy      = (state != ST_ACTIVE);
    assign sel.cur_id    = cur_id;
    assign sel.sel_err   = err_q;
endmodule

// File: tb/tb_heichips25_multi_wrapper.sv
// Scoreboard bench for the multi-project pad wrapper: a 4-slot instance checked every cycle
// against a timeline model, plus a 3-slot instance for out-of-range selects.
module tb_heichips25_multi_wrapper;
    localparam int NP    = 4;
    localparam int NPB   = 3;
    localparam int IO_W  = 8;
    localparam int GUARD = 4;
    localparam int RSTC  = 8;

    localparam int POST_ACTIVE = 0;
    localparam int POST_DRAIN  = 1;
    localparam int POST_RESET  = 2;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    always #5 clk = ~clk;

    heichips25_multi_wrapper_if #(.NUM_PROJECTS(NP))  sel_a ();
    heichips25_multi_wrapper_if #(.NUM_PROJECTS(NPB)) sel_b ();

    logic [NP*IO_W-1:0]  a_uo, a_uio, a_oe;
    logic [NP-1:0]       a_pena, a_prst;
    logic [IO_W-1:0]     a_uo_out, a_uio_out, a_uio_oe;

    logic [NPB*IO_W-1:0] b_uo, b_uio, b_oe;
    logic [NPB-1:0]      b_pena, b_prst;
    logic [IO_W-1:0]     b_uo_out, b_uio_out, b_uio_oe;

    heichips25_multi_wrapper #(
        .NUM_PROJECTS(NP), .IO_W(IO_W), .DEFAULT_ID(0),
        .GUARD_CYCLES(GUARD), .RST_CYCLES(RSTC)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .sel(sel_a.slave),
        .proj_uo_out(a_uo), .proj_uio_out(a_uio), .proj_uio_oe(a_oe),
        .proj_ena(a_pena), .proj_rst_n(a_prst),
        .uo_out(a_uo_out), .uio_out(a_uio_out), .uio_oe(a_uio_oe)
    );

    heichips25_multi_wrapper #(
        .NUM_PROJECTS(NPB), .IO_W(IO_W), .DEFAULT_ID(0),
        .GUARD_CYCLES(GUARD), .RST_CYCLES(RSTC)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .sel(sel_b.slave),
        .proj_uo_out(b_uo), .proj_uio_out(b_uio), .proj_uio_oe(b_oe),
        .proj_ena(b_pena), .proj_rst_n(b_prst),
        .uo_out(b_uo_out), .uio_out(b_uio_out), .uio_oe(b_uio_oe)
    );

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
        logic [3:0] pena;
        logic [3:0] prst;
        logic       ready;
        logic       busy;
        logic       err;
        logic [1:0] cur;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Timeline model: m_pend counts the edges still ending in a dark state.
    int m_pend;
    int m_cur;
    int m_next;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        m_pend = RSTC - 1;
        m_cur  = 0;
        m_next = 0;
    endtask

    // One clock: drive fresh bus data, predict post-edge outputs, then compare.
    task automatic applyStimulus(input bit fix_a5);
        exp_t e;
        int   pre_cur;
        int   post;
        a_uo  = $urandom;
        a_uio = $urandom;
        a_oe  = $urandom;
        if (fix_a5) a_uo[7:0] = 8'hA5;
        pre_cur = m_cur;
        if (sel_a.sel_valid && m_pend == 0) begin
            m_next = int'(sel_a.sel_id);
            m_pend = GUARD + RSTC;
        end
        if (m_pend == 0) begin
            post = POST_ACTIVE;
        end else if (m_pend > RSTC) begin
            post = POST_DRAIN;
        end else begin
            post  = POST_RESET;
            m_cur = m_next;
        end
        e.uo    = (post == POST_ACTIVE && ena) ? a_uo[pre_cur*IO_W +: IO_W]  : 8'h00;
        e.uio   = (post == POST_ACTIVE && ena) ? a_uio[pre_cur*IO_W +: IO_W] : 8'h00;
        e.oe    = (post == POST_ACTIVE && ena) ? a_oe[pre_cur*IO_W +: IO_W]  : 8'h00;
        e.pena  = (ena && post != POST_DRAIN) ? 4'(1 << m_cur) : 4'b0000;
        e.prst  = (post != POST_RESET) ? 4'(1 << m_cur) : 4'b0000;
        e.ready = (post == POST_ACTIVE);
        e.busy  = (post != POST_ACTIVE);
        e.err   = 1'b0;
        e.cur   = 2'(m_cur);
        exp_q.push_back(e);
        if (m_pend > 0) m_pend--;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput("uo_out",     a_uo_out,        e.uo);
        checkOutput("uio_out",    a_uio_out,       e.uio);
        checkOutput("uio_oe",     a_uio_oe,        e.oe);
        checkOutput("proj_ena",   a_pena,          e.pena);
        checkOutput("proj_rst_n", a_prst,          e.prst);
        checkOutput("sel_ready",  sel_a.sel_ready, e.ready);
        checkOutput("busy",       sel_a.busy,      e.busy);
        checkOutput("sel_err",    sel_a.sel_err,   e.err);
        checkOutput("cur_id",     sel_a.cur_id,    e.cur);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_uo"},    a_uo_out,        8'h00);
        checkOutput({tag, "_oe"},    a_uio_oe,        8'h00);
        checkOutput({tag, "_pena"},  a_pena,          4'b0000);
        checkOutput({tag, "_prst"},  a_prst,          4'b0000);
        checkOutput({tag, "_busy"},  sel_a.busy,      1'b1);
        checkOutput({tag, "_ready"}, sel_a.sel_ready, 1'b0);
        checkOutput({tag, "_cur"},   sel_a.cur_id,    2'd0);
    endtask

    task automatic selectSlot(input logic [1:0] id, input int tail);
        sel_a.sel_valid = 1'b1;
        sel_a.sel_id    = id;
        applyStimulus(1'b0);
        sel_a.sel_valid = 1'b0;
        repeat (tail) applyStimulus(1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        ena             = 1'b1;
        sel_a.sel_valid = 1'b0;
        sel_a.sel_id    = 2'd0;
        sel_b.sel_valid = 1'b0;
        sel_b.sel_id    = 2'd0;
        a_uo            = '0;
        a_uio           = '0;
        a_oe            = '0;
        b_uo            = 24'h22113C;
        b_uio           = 24'h665544;
        b_oe            = 24'hAA99F0;
        resetModel();

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("reset_err", sel_a.sel_err, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        resetModel();
        repeat (RSTC - 1) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("first_a5", a_uo_out, 8'hA5);
        repeat (3) applyStimulus(1'b0);

        $display("[TB] switch to slot 2");
        selectSlot(2'd2, GUARD + RSTC + 2);
        checkOutput("slot2_ena", a_pena, 4'b0100);

        $display("[TB] switch to slot 1, then re-select slot 1");
        selectSlot(2'd1, GUARD + RSTC + 2);
        selectSlot(2'd1, GUARD + RSTC + 2);

        $display("[TB] ena low while active");
        ena = 1'b0;
        repeat (3) applyStimulus(1'b0);
        ena = 1'b1;
        repeat (2) applyStimulus(1'b0);

        $display("[TB] out-of-range select on 3-slot instance");
        sel_b.sel_valid = 1'b1;
        sel_b.sel_id    = 2'd3;
        applyStimulus(1'b0);
        checkOutput("b_err_pulse", sel_b.sel_err,   1'b1);
        checkOutput("b_cur",       sel_b.cur_id,    2'd0);
        checkOutput("b_busy",      sel_b.busy,      1'b0);
        checkOutput("b_uo",        b_uo_out,        8'h3C);
        checkOutput("b_oe",        b_uio_oe,        8'hF0);
        sel_b.sel_valid = 1'b0;
        applyStimulus(1'b0);
        checkOutput("b_err_clear", sel_b.sel_err,   1'b0);
        checkOutput("b_uo_after",  b_uo_out,        8'h3C);
        checkOutput("b_ready",     sel_b.sel_ready, 1'b1);

        $display("[TB] reset during drain towards slot 3");
        selectSlot(2'd3, 2);
        rst = 1'b1;
        #1;
        checkResetState("midrst");
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        repeat (RSTC + 3) applyStimulus(1'b0);
        checkOutput("slot3_never", a_pena[3],    1'b0);
        checkOutput("back_to_0",   sel_a.cur_id, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
